// File: rtl/cam_capture_px.sv
// rtl/cam_capture_px.sv - DVP byte-pair capture into linear frame-buffer writes
// Optional 2x decimation (and the i_decim port) is enabled by defining CAM_CAPTURE_DECIM_EN.
module cam_capture_px #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PIX_W       = 12,
    parameter int SKIP_FRAMES = 1,
    parameter int ADDR_W      = 19
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    input  logic              i_cam_done,
`ifdef CAM_CAPTURE_DECIM_EN
    input  logic              i_decim,
`endif
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_wr,
    output logic              o_frame_done,
    output logic [2:0]        o_err
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_ACTIVE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          skip_cnt_q, skip_cnt_d;
    logic                phase_q, phase_d;
    logic [7:0]          byte0_q, byte0_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                line_px_q, line_px_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                decim_q, decim_d;
    logic                wr_q, wr_d;
    logic                fd_q, fd_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [PIX_W-1:0]    pix_data_q, pix_data_d;
    logic [2:0]          err_q, err_d;

    logic                frame_start, frame_end, href_fall;
    logic                start_frame, capture, decim_in;
    logic [15:0]         pix16;
    logic [11:0]         pix12;
    logic [PIX_W-1:0]    pix_word;

`ifdef CAM_CAPTURE_DECIM_EN
    assign decim_in = i_decim;
`else
    assign decim_in = 1'b0;
`endif

    assign frame_start = vsync_q & ~i_vsync;
    assign frame_end   = ~vsync_q & i_vsync;
    assign href_fall   = href_q & ~i_href;

    assign pix16    = {byte0_q, i_D};
    assign pix12    = {byte0_q[3:0], i_D};
    assign pix_word = (PIX_W == 16) ? PIX_W'(pix16) : PIX_W'(pix12);

    always_comb begin
        state_d     = state_q;
        vsync_d     = i_vsync;
        href_d      = i_href;
        skip_cnt_d  = skip_cnt_q;
        phase_d     = phase_q;
        byte0_d     = byte0_q;
        col_d       = col_q;
        row_d       = row_q;
        line_px_d   = line_px_q;
        base_d      = base_q;
        addr_d      = addr_q;
        decim_d     = decim_q;
        wr_d        = 1'b0;
        fd_d        = 1'b0;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;
        err_d       = err_q;
        start_frame = 1'b0;
        capture     = 1'b0;

        if (!i_cam_done) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SKIP;
                    skip_cnt_d = 8'd0;
                end
                ST_SKIP: begin
                    if (frame_start) begin
                        if (skip_cnt_q == 8'(SKIP_FRAMES)) begin
                            state_d     = ST_ACTIVE;
                            start_frame = 1'b1;
                        end else begin
                            skip_cnt_d = skip_cnt_q + 8'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (frame_end) begin
                        state_d = ST_WAIT;
                        fd_d    = 1'b1;
                        phase_d = 1'b0;
                    end else if (frame_start) begin
                        start_frame = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (frame_start) begin
                        state_d     = ST_ACTIVE;
                        start_frame = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_frame) begin
            col_d     = '0;
            row_d     = '0;
            base_d    = '0;
            addr_d    = '0;
            phase_d   = 1'b0;
            line_px_d = 1'b0;
            decim_d   = decim_in;
        end

        if (capture) begin
            if (i_href) begin
                if (!phase_q) begin
                    byte0_d = i_D;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (row_q == ROW_W'(V_ACTIVE)) begin
                        err_d[0] = 1'b1;
                    end else if (col_q == COL_W'(H_ACTIVE)) begin
                        err_d[1] = 1'b1;
                    end else begin
                        col_d     = col_q + COL_W'(1);
                        line_px_d = 1'b1;
                        // Decimated pixels still advance col so the overflow limit stays undecimated.
                        if (!decim_q || (!row_q[0] && !col_q[0])) begin
                            wr_d       = 1'b1;
                            pix_addr_d = addr_q;
                            pix_data_d = pix_word;
                            addr_d     = addr_q + ADDR_W'(1);
                        end
                    end
                end
            end else begin
                phase_d = 1'b0;
                if (href_fall) begin
                    if (phase_q) err_d[2] = 1'b1;
                    col_d     = '0;
                    line_px_d = 1'b0;
                    // Line base steps by one output row; short lines leave the gap unwritten.
                    if (line_px_q) begin
                        row_d = row_q + ROW_W'(1);
                        if (!decim_q) begin
                            base_d = base_q + ADDR_W'(H_ACTIVE);
                            addr_d = base_q + ADDR_W'(H_ACTIVE);
                        end else if (row_q[0]) begin
                            base_d = base_q + ADDR_W'(H_ACTIVE / 2);
                            addr_d = base_q + ADDR_W'(H_ACTIVE / 2);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            skip_cnt_q <= 8'd0;
            phase_q    <= 1'b0;
            byte0_q    <= 8'd0;
            col_q      <= '0;
            row_q      <= '0;
            line_px_q  <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            decim_q    <= 1'b0;
            wr_q       <= 1'b0;
            fd_q       <= 1'b0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            skip_cnt_q <= skip_cnt_d;
            phase_q    <= phase_d;
            byte0_q    <= byte0_d;
            col_q      <= col_d;
            row_q      <= row_d;
            line_px_q  <= line_px_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            decim_q    <= decim_d;
            wr_q       <= wr_d;
            fd_q       <= fd_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
            err_q      <= err_d;
        end
    end

    assign o_pix_addr   = pix_addr_q;
    assign o_pix_data   = pix_data_q;
    assign o_wr         = wr_q;
    assign o_frame_done = fd_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_cam_capture_px.sv
// tb/tb_cam_capture_px.sv - directed bench for cam_capture_px with a frame-level write model
module tb_cam_capture_px;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 7;

    logic        clk = 1'b0;
    logic        rst, vsync, href, cam_done;
    logic [7:0]  d;
`ifdef CAM_CAPTURE_DECIM_EN
    logic        decim;
`endif
    logic [AW-1:0] addr12, addr16;
    logic [11:0]   data12;
    logic [15:0]   data16;
    logic          wr12, wr16, fd12, fd16;
    logic [2:0]    err12, err16;

    always #5 clk = ~clk;

    cam_capture_px #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(12), .SKIP_FRAMES(1), .ADDR_W(AW)) dut (
        .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_href(href), .i_D(d), .i_cam_done(cam_done),
`ifdef CAM_CAPTURE_DECIM_EN
        .i_decim(decim),
`endif
        .o_pix_addr(addr12), .o_pix_data(data12), .o_wr(wr12), .o_frame_done(fd12), .o_err(err12)
    );

    cam_capture_px #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(16), .SKIP_FRAMES(1), .ADDR_W(AW)) dut16 (
        .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_href(href), .i_D(d), .i_cam_done(cam_done),
`ifdef CAM_CAPTURE_DECIM_EN
        .i_decim(decim),
`endif
        .o_pix_addr(addr16), .o_pix_data(data16), .o_wr(wr16), .o_frame_done(fd16), .o_err(err16)
    );

    typedef struct {
        int          addr;
        logic [11:0] d12;
        logic [15:0] d16;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  lb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_cnt = 0;
    int          fd_seen = 0;
    int          seed = 0;
    int          w0;
    logic        prev_wr = 1'b0;
    bit          m_cap = 1'b0;
    bit          m_decim = 1'b0;
    int          m_row = 0;
    logic [2:0]  m_err = 3'b000;
    int          m_fd_exp = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fd12) fd_seen++;
        if (wr12) chk("wr_spacing", prev_wr, 0);
        if (wr12 || wr16) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_wr: got write at addr %0d, expected none", addr12);
            end else begin
                e = exp_q.pop_front();
                chk("wr12", wr12, 1);
                chk("wr16", wr16, 1);
                chk("pix_addr", addr12, e.addr);
                chk("pix_data12", data12, e.d12);
                chk("pix_data16", data16, e.d16);
                wr_cnt++;
            end
        end
        prev_wr = wr12;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_pixel(input int px, input logic [7:0] b0, input logic [7:0] b1);
        exp_t e;
        if (m_row >= V) m_err[0] = 1'b1;
        else if (px >= H) m_err[1] = 1'b1;
        else if (!m_decim || (m_row % 2 == 0 && px % 2 == 0)) begin
            e.addr = m_decim ? (m_row / 2) * (H / 2) + px / 2 : m_row * H + px;
            e.d12  = {b0[3:0], b1};
            e.d16  = {b0, b1};
            exp_q.push_back(e);
        end
    endtask

    task automatic mk(input int n);
        lb.delete();
        for (int i = 0; i < n; i++) begin
            lb.push_back(8'(seed * 29 + 7));
            seed++;
        end
    endtask

    task automatic send(input bit drop);
        for (int i = 0; i < lb.size(); i++) begin
            tick();
            href = 1'b1;
            d    = lb[i];
            if (i % 2 == 1 && m_cap) model_pixel(i / 2, lb[i-1], lb[i]);
        end
        if (drop) begin
            tick();
            href = 1'b0;
            if (m_cap) begin
                if (lb.size() % 2 == 1) m_err[2] = 1'b1;
                if (lb.size() >= 2 && m_row < V) m_row++;
            end
            repeat (3) tick();
        end
    endtask

    task automatic frame_start(input bit cap, input bit dec);
        tick();
        vsync = 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
        decim = dec;
`endif
        m_cap   = cap;
        m_decim = dec;
        m_row   = 0;
        repeat (2) tick();
    endtask

    task automatic frame_end();
        tick();
        vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("frame_done", fd12, m_cap);
        if (m_cap) m_fd_exp++;
        m_cap = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame(input bit cap, input int nlines, input int nbytes);
        frame_start(cap, 1'b0);
        repeat (nlines) begin
            mk(nbytes);
            send(1'b1);
        end
        frame_end();
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00; cam_done = 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
        decim = 1'b0;
`endif
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr", wr12, 0);
        chk("rst_frame_done", fd12, 0);
        chk("rst_addr", addr12, 0);
        chk("rst_data12", data12, 0);
        chk("rst_data16", data16, 0);
        chk("rst_err", err12, 0);
        tick();
        rst = 1'b0;

        frame(1'b0, V, 2 * H);
        cam_done = 1'b1;
        repeat (2) tick();
        frame(1'b0, V, 2 * H);
        @(negedge clk);
        chk("skip_addr", addr12, 0);
        chk("skip_data", data12, 0);
        chk("skip_err", err12, 0);
        chk("skip_writes", wr_cnt, 0);

        w0 = wr_cnt;
        frame(1'b1, V, 2 * H);
        chk("frame_writes", wr_cnt - w0, 128);
        chk("frame_last_addr", addr12, 127);
        chk("frame_done_count", fd_seen, 1);

        frame_start(1'b1, 1'b0);
        lb = {8'hA5, 8'h3C};
        send(1'b1);
        @(negedge clk);
        chk("lit_data12", data12, 12'h53C);
        chk("lit_data16", data16, 16'hA53C);
        chk("lit_addr", addr12, 0);
        mk(2 * H + 1);
        send(1'b1);
        chk("odd_err", err12, 3'b100);
        chk("odd_model_err", err12, m_err);
        mk(4);
        send(1'b1);
        chk("next_line_addr", addr12, 33);
        frame_end();

        frame_start(1'b1, 1'b0);
        mk(2 * H + 2);
        send(1'b1);
        chk("col_ovf_err", err12, 3'b110);
        repeat (V) begin
            mk(2 * H);
            send(1'b1);
        end
        frame_end();
        chk("row_ovf_err", err12, 3'b111);
        chk("ovf_model_err", err12, m_err);
        chk("ovf_last_addr", addr12, 127);

        frame_start(1'b1, 1'b0);
        repeat (2) begin
            mk(2 * H);
            send(1'b1);
        end
        lb = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send(1'b0);
        tick();
        d   = 8'h66;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wr", wr12, 0);
        chk("mid_rst_addr", addr12, 0);
        chk("mid_rst_data12", data12, 0);
        chk("mid_rst_data16", data16, 0);
        chk("mid_rst_err", err12, 0);
        chk("mid_rst_frame_done", fd12, 0);
        m_cap = 1'b0;
        m_err = 3'b000;
        href  = 1'b0;
        tick();
        rst = 1'b0;
        frame_end();
        w0 = wr_cnt;
        frame(1'b0, V, 2 * H);
        chk("post_rst_skip_writes", wr_cnt - w0, 0);
        w0 = wr_cnt;
        frame(1'b1, V, 2 * H);
        chk("post_rst_writes", wr_cnt - w0, 128);
        chk("post_rst_err", err12, 0);

`ifdef CAM_CAPTURE_DECIM_EN
        w0 = wr_cnt;
        frame_start(1'b1, 1'b1);
        repeat (V) begin
            mk(2 * H);
            send(1'b1);
        end
        frame_end();
        chk("decim_writes", wr_cnt - w0, 32);
        chk("decim_last_addr", addr12, 31);
`endif

        repeat (4) tick();
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("frame_done_total", fd_seen, m_fd_exp);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cam_capture_px.md
# cam_capture_px

Parametrised successor to the OV7670 capture path. Sits between the camera's raw DVP bus (PCLK domain) and the frame-buffer write port. Skips a configurable number of frames after camera configuration completes, then assembles two-byte pixels (RGB444 or RGB565) into write strobes with linear addresses. Adds frame-done signalling, geometry-overflow and odd-byte error flags, and optional 2x decimation.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- PIX_W, 12, output pixel width; 12 gives {byte0[3:0], byte1}, 16 gives {byte0, byte1}; other values illegal
- SKIP_FRAMES, 1, whole frames discarded after i_cam_done rises (0..255)
- ADDR_W, 19, address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

- i_pclk  in  1  pixel clock; the only clock
- i_rst  in  1  reset, synchronous, active-high
- i_vsync  in  1  camera VSYNC; high = vertical blanking
- i_href  in  1  camera HREF; high = valid bytes on i_D
- i_D  in  8  camera data byte
- i_cam_done  in  1  camera register configuration complete (level)
- i_decim  in  1  2x decimation request (present only with CAM_CAPTURE_DECIM_EN)
- o_pix_addr  out  ADDR_W  linear address of pixel on o_pix_data
- o_pix_data  out  PIX_W  assembled pixel
- o_wr  out  1  one-cycle write strobe
- o_frame_done  out  1  one-cycle pulse at end of a captured frame
- o_err  out  3  sticky {odd_byte, col_ovf, row_ovf}

## Operation
- All inputs sampled on posedge i_pclk. vsync_q holds the previous sample. Frame start = vsync fall (vsync_q=1, i_vsync=0). Frame end = vsync rise.
- FSM states:
  - IDLE: entered on reset. Moves to SKIP when i_cam_done=1; skip counter is cleared on entry.
  - SKIP: counts frame starts. The frame start numbered SKIP_FRAMES+1 moves to ACTIVE. With SKIP_FRAMES=0, the first frame start goes to ACTIVE.
  - ACTIVE: captures bytes. Frame end pulses o_frame_done and moves to WAIT.
  - WAIT: the next frame start moves to ACTIVE.
- From any state, i_cam_done=0 moves the FSM to IDLE on the next edge. Any partial pixel is dropped.
- Byte assembly, in ACTIVE with i_href=1:
  - phase=0: latch byte0.
  - phase=1: form the pixel and write it.
  - phase clears while i_href=0.
- href fall with phase=1 (odd byte count): discard byte0, set o_err[2].
- Counters: col (0..H_ACTIVE-1) and row (0..V_ACTIVE-1).
  - Both clear at frame start. col clears at href fall; row increments at href fall only if at least one pixel was written on that line.
  - Address = row*H_ACTIVE + col, kept as an incrementing register (no multiplier). It resets to 0 at frame start and is not reset between lines.
- Overflow:
  - Pixel with col = H_ACTIVE: not written, o_err[1] set.
  - Line with row = V_ACTIVE: no pixels written, o_err[0] set.
- o_err clears only on i_rst.
- No writes outside ACTIVE. A frame start seen in ACTIVE (no preceding frame end) restarts the frame: counters cleared, no o_frame_done.

## Timing
- Reset values: o_wr=0, o_frame_done=0, o_pix_addr=0, o_pix_data=0, o_err=0, FSM=IDLE, phase=0.
- Latency: o_wr, o_pix_data and o_pix_addr update on the same edge that samples byte1, so they are valid one cycle after byte1 is on i_D. The strobe lasts one cycle.
- Minimum spacing between o_wr pulses: 2 cycles.
- o_pix_addr and o_pix_data hold their last written values between strobes.
- The first pixel of a frame has address 0. Pixel k of line r has address r*H_ACTIVE + k.
- o_frame_done is asserted on the edge that detects the vsync rise.
- i_rst has priority over every other event, including mid-pixel and mid-frame. After reset, capture needs i_cam_done and SKIP_FRAMES full skipped frames again.

## Configuration
- CAM_CAPTURE_DECIM_EN defined:
  - i_decim port exists; it is sampled only at frame start and held for the frame.
  - When held 1: only even pixels of even lines are written. Address = (row/2)*(H_ACTIVE/2) + col/2. Overflow limits still apply to the undecimated col/row.
- Not defined: no i_decim port; every pixel is written.

## Test plan
- SKIP_FRAMES=1: raise i_cam_done, run one full 640x480 frame -> o_wr never asserted, all outputs 0. Next frame -> 307200 writes; addresses 0..307199 in order; o_frame_done pulses once at the vsync rise.
- Bytes 0xA5, 0x3C with PIX_W=12 -> o_pix_data=0x53C. Same bytes with PIX_W=16 -> 0xA53C. o_wr high for exactly one cycle after 0x3C is sampled.
- Line of 641 bytes -> 320 writes, o_err=3'b100, next line starts at address 640.
- Line of 1282 bytes -> 640 writes, o_err[1]=1. 481 lines -> o_err[0]=1, last address 307199.
- i_rst asserted mid-line at address 1000 -> all outputs 0 next cycle. After release, the next frame is skipped.
- With CAM_CAPTURE_DECIM_EN and i_decim=1 -> 76800 writes per frame, addresses 0..76799; line 2 pixel 0 has address 320.
